// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg.
// Upstream (in_*) and downstream (out_*) sides share one interface.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline register with 2-entry skid buffer, flush and stall counter.
// in_ready is decoded from the state flops only.
module pipe_skid_reg #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  pipe_skid_reg_if.slave       bus,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign bus.out_valid = (state_q != EMPTY);
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_data  = main_q;
  assign occupancy     = state_q;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = bus.in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = bus.in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash leaves data regs stale; only the state is cleared.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready
                 && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg.
// Directed cases followed by a random handshake run.
module tb_pipe_skid_reg;
  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             flush;
  logic [1:0]       occupancy;
  logic [7:0]       stall_cnt;

  pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_skid_reg #(
    .WIDTH(WIDTH),
    .RESET_VALUE(16'h0000),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int m_stall = 0;
  logic [WIDTH-1:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Compare outputs mid-cycle, then advance the model to the next edge.
  task automatic step();
    bit m_rdy, m_vld, in_f, out_f;
    @(negedge clk);
    m_rdy = (q.size() < 2);
    m_vld = (q.size() != 0);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_vld});
    chk("occ", {30'd0, occupancy}, q.size());
    chk("stall", {24'd0, stall_cnt}, m_stall);
    if (m_vld)
      chk("data", {16'd0, bus.out_data}, {16'd0, q[0]});
    in_f  = bus.in_valid && m_rdy;
    out_f = bus.out_ready && m_vld;
    if (reset) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (m_vld && !bus.out_ready && m_stall < 255)
        m_stall++;
      if (out_f) begin
        void'(q.pop_front());
        n_out++;
      end
      if (in_f)
        q.push_back(bus.in_data);
      if (flush)
        q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d,
                       input bit r, input bit f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
  endtask

  initial begin
    int n0;
    reset = 1'b1;
    drive(1'b1, 16'h5A5A, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_data", {16'd0, bus.out_data}, 0);
    chk("rst_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_occ", {30'd0, occupancy}, 0);
    chk("rst_stall", {24'd0, stall_cnt}, 0);
    q.delete();
    m_stall = 0;
    reset = 1'b0;

    n0 = n_out;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, i[15:0], 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("stream_cnt", n_out - n0, 16);

    drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'hCCCC, 1'b0, 1'b0);
    chk("full_occ", {30'd0, occupancy}, 2);
    chk("full_rdy", {31'd0, bus.in_ready}, 0);
    chk("full_data", {16'd0, bus.out_data}, 16'hAAAA);
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (3) step();
    chk("drain_occ", {30'd0, occupancy}, 0);

    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h3333, 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("flush_occ", {30'd0, occupancy}, 0);
    chk("flush_vld", {31'd0, bus.out_valid}, 0);
    chk("flush_rdy", {31'd0, bus.in_ready}, 1);
    repeat (2) step();

    drive(1'b1, 16'h7777, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    repeat (300) step();
    chk("stall_sat", {24'd0, stall_cnt}, 255);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("stall_rst", {24'd0, stall_cnt}, 0);

    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (3) step();
    chk("end_occ", {30'd0, occupancy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
